// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and constants for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_OR   = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_NOT  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHRA = 4'd6;
    localparam logic [3:0] ALU_SHL  = 4'd7;
    localparam logic [3:0] ALU_ROR  = 4'd8;
    localparam logic [3:0] ALU_ROL  = 4'd9;
    localparam logic [3:0] ALU_NEG  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    // Quotient on divide-by-zero is this bit replicated across the word.
    localparam logic DIV0_QUO_FILL = 1'b1;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative datapath: radix-2 Booth multiply and restoring magnitude divide,
// one bit per step, sharing the hi/lo accumulator pair and iteration counter.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    load,
    input  logic                    load_div,
    input  logic                    step,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    last,
    output logic [2*WIDTH-1:0]      prod_nxt,
    output logic [WIDTH-1:0]        quo,
    output logic [WIDTH-1:0]        rem
);

    localparam logic [SHW:0] CNT_END = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    logic [WIDTH:0]   hi, hi_nxt, booth_sum, div_shl, div_diff, m_ext;
    logic [WIDTH-1:0] lo, lo_nxt, m;
    logic             qm1, qm1_nxt, div_mode, neg_a, neg_b;
    logic [SHW:0]     cnt;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_comb begin
        m_ext = {m[WIDTH-1], m};
        case ({lo[0], qm1})
            2'b01:   booth_sum = hi + m_ext;
            2'b10:   booth_sum = hi - m_ext;
            default: booth_sum = hi;
        endcase
        div_shl  = {hi[WIDTH-1:0], lo[WIDTH-1]};
        div_diff = div_shl - {1'b0, m};
        if (div_mode) begin
            qm1_nxt = qm1;
            if (!div_diff[WIDTH]) begin
                hi_nxt = div_diff;
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = div_shl;
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Booth step ends with an arithmetic shift of the whole {hi,lo,q-1} chain.
            hi_nxt  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            lo_nxt  = {booth_sum[0], lo[WIDTH-1:1]};
            qm1_nxt = lo[0];
        end
    end

    assign prod_nxt = {hi_nxt[WIDTH-1:0], lo_nxt};
    assign quo      = (neg_a ^ neg_b) ? -lo : lo;
    assign rem      = neg_a ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
    assign last     = (cnt == CNT_END - CNT_ONE);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (step && cnt != CNT_END)
            cnt <= cnt + CNT_ONE;
    end

    always_ff @(posedge clock) begin
        if (load) begin
            hi       <= '0;
            qm1      <= 1'b0;
            div_mode <= load_div;
            if (load_div) begin
                lo    <= mag(a);
                m     <= mag(b);
                neg_a <= a[WIDTH-1];
                neg_b <= b[WIDTH-1];
            end else begin
                lo    <= a;
                m     <= b;
                neg_a <= 1'b0;
                neg_b <= 1'b0;
            end
        end else if (step) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            qm1 <= qm1_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops plus iterative MUL/DIV
// behind a start/busy/done handshake; result is {HI,LO}.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    state_t             state, state_nxt;
    logic               accept, is_mul, is_div, div_zero, core_load, core_step, core_last;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   quo, rem;

    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] code,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [SHW-1:0]     sh;
        logic [2*WIDTH-1:0] rot;
        sh = b[SHW-1:0];
        case (code)
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_NOT:  return ~b;
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SHR:  return a >> sh;
            ALU_SHRA: return $signed(a) >>> sh;
            ALU_SHL:  return a << sh;
            ALU_ROR: begin
                rot = {a, a} >> sh;
                return rot[WIDTH-1:0];
            end
            ALU_ROL: begin
                rot = {a, a} << sh;
                return rot[2*WIDTH-1:WIDTH];
            end
            ALU_NEG:  return -b;
            default:  return '0;
        endcase
    endfunction

    always_comb begin
        busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
        done      = (state == S_DONE);
        accept    = start && !busy;
        is_mul    = (op == ALU_MUL);
        is_div    = (op == ALU_DIV);
        div_zero  = is_div && (B == '0);
        core_load = accept && (is_mul || (is_div && !div_zero));
        core_step = (state == S_MUL) || (state == S_DIV);
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (!accept)
                    state_nxt = S_IDLE;
                else if (is_mul)
                    state_nxt = S_MUL;
                else if (is_div && !div_zero)
                    state_nxt = S_DIV;
                else
                    state_nxt = S_DONE;
            end
            S_MUL:   if (core_last) state_nxt = S_DONE;
            S_DIV:   if (core_last) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Result changes only on the edge that enters DONE; iteration never disturbs it.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && !core_load) begin
            div_by_zero <= div_zero;
            result      <= div_zero ? {A, {WIDTH{DIV0_QUO_FILL}}}
                                    : {{WIDTH{1'b0}}, single_op(op, A, B)};
        end else if (accept) begin
            div_by_zero <= 1'b0;
        end else if (state == S_MUL && core_last) begin
            result <= prod_nxt;
        end else if (state == S_FIX) begin
            result <= {rem, quo};
        end
    end

    seq_muldiv_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .clock    (clock),
        .clear_n  (clear_n),
        .load     (core_load),
        .load_div (is_div),
        .step     (core_step),
        .a        (A),
        .b        (B),
        .last     (core_last),
        .prod_nxt (prod_nxt),
        .quo      (quo),
        .rem      (rem)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations come from a behavioural model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic           clock = 1'b0;
    logic           clear_n, start;
    logic [3:0]     op;
    logic [W-1:0]   A, B;
    logic           busy, done, div_by_zero;
    logic [2*W-1:0] result;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [2*W-1:0] res;
        logic           dbz;
        int             lat;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    seq_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0]          r;
        logic signed [W-1:0]   q, rm;
        logic signed [2*W-1:0] p;
        int n;
        n     = int'(b[4:0]);
        r     = '0;
        e.dbz = 1'b0;
        e.lat = 1;
        case (o)
            4'd0:  r = a | b;
            4'd1:  r = a & b;
            4'd2:  r = ~b;
            4'd3:  r = a + b;
            4'd4:  r = a - b;
            4'd5:  r = a >> n;
            4'd6:  r = $signed(a) >>> n;
            4'd7:  r = a << n;
            4'd8:  r = (n == 0) ? a : ((a >> n) | (a << (W - n)));
            4'd9:  r = (n == 0) ? a : ((a << n) | (a >> (W - n)));
            4'd10: r = ~b + 32'd1;
            default: r = '0;
        endcase
        e.res = {32'd0, r};
        if (o == 4'd11) begin
            p     = $signed(a) * $signed(b);
            e.res = p;
            e.lat = W + 1;
        end else if (o == 4'd12) begin
            if (b == 0) begin
                e.res = {a, 32'hFFFF_FFFF};
                e.dbz = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.res = {32'd0, 32'h8000_0000};
                e.lat = W + 2;
            end else begin
                q     = $signed(a) / $signed(b);
                rm    = $signed(a) % $signed(b);
                e.res = {rm, q};
                e.lat = W + 2;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int c0);
        @(negedge clock);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        sb.push_back(model(o, a, b));
        c0 = cyc;
    endtask

    task automatic wait_done(input int max, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (done === 1'b1) begin
                at = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        clear_n = 1'b0;
        start   = 1'b0;
        op      = '0;
        A       = '0;
        B       = '0;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        clear_n = 1'b1;
    endtask

    task automatic test_single_cycle;
        logic [3:0]   ops [12];
        logic [W-1:0] as  [12];
        logic [W-1:0] bs  [12];
        int c0, at;
        bit ok;
        exp_t e;
        ops = '{ALU_ADD, ALU_ROR, ALU_OR, ALU_AND, ALU_NOT, ALU_SUB,
                ALU_SHR, ALU_SHRA, ALU_SHL, ALU_ROL, ALU_NEG, 4'd14};
        as  = '{32'h7FFF_FFFF, 32'h0000_000F, 32'h0000_00F0, 32'hFF00_FF00, 32'h1234_5678, 32'h0,
                32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h8000_0001, 32'h0, 32'h1};
        bs  = '{32'h1, 32'h24, 32'h0F, 32'h0FF0_0FF0, 32'h5A5A_5A5A, 32'h1,
                32'h1F, 32'h4, 32'h20, 32'h1, 32'h1, 32'h2};
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i], c0);
            wait_done(5, at, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || at - c0 != e.lat) begin
                errors++; $display("FAIL single_latency op=%0d got=%0d want=%0d", ops[i], at - c0, e.lat);
            end
            checks++;
            if (result !== e.res) begin
                errors++; $display("FAIL single_result op=%0d got=%h want=%h", ops[i], result, e.res);
            end
            checks++;
            if (div_by_zero !== e.dbz) begin
                errors++; $display("FAIL single_dbz op=%0d got=%b want=%b", ops[i], div_by_zero, e.dbz);
            end
        end
    endtask

    task automatic test_mul_stray_start;
        int c0, at;
        bit both;
        exp_t e;
        logic [2*W-1:0] held;
        issue(ALU_MUL, 32'hFFFF_FFF9, 32'd6, c0);
        at   = -1;
        both = 1'b0;
        for (int k = 1; k <= 40 && at < 0; k++) begin
            @(negedge clock);
            if (done === 1'b1) at = cyc;
            if (done === 1'b1 && busy === 1'b1) both = 1'b1;
            if (k == 5) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_t5 got=%b want=1", busy); end
                op = ALU_ADD; A = 32'd1; B = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        e = sb.pop_front();
        checks++; if (at - c0 != e.lat) begin errors++; $display("FAIL mul_latency got=%0d want=%0d", at - c0, e.lat); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL mul_result got=%h want=%h", result, e.res); end
        checks++; if (both) begin errors++; $display("FAIL mul_busy_done_overlap got=1 want=0"); end
        held = result;
        repeat (3) @(negedge clock);
        checks++; if (done !== 1'b0 || result !== held) begin
            errors++; $display("FAIL mul_stray_ignored done=%b result=%h want done=0 result=%h", done, result, held);
        end
    endtask

    task automatic test_muldiv_table;
        logic [3:0]   ops [7];
        logic [W-1:0] as  [7];
        logic [W-1:0] bs  [7];
        int c0, at;
        bit ok;
        exp_t e;
        ops = '{ALU_DIV, ALU_DIV, ALU_DIV, ALU_DIV, ALU_DIV, ALU_MUL, ALU_MUL};
        as  = '{32'hFFFF_FFEF, 32'd9, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'h7FFF_FFFF};
        bs  = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], c0);
            wait_done(40, at, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || at - c0 != e.lat) begin
                errors++; $display("FAIL muldiv_latency case=%0d got=%0d want=%0d", i, at - c0, e.lat);
            end
            checks++;
            if (result !== e.res) begin
                errors++; $display("FAIL muldiv_result case=%0d got=%h want=%h", i, result, e.res);
            end
            checks++;
            if (div_by_zero !== e.dbz) begin
                errors++; $display("FAIL muldiv_dbz case=%0d got=%b want=%b", i, div_by_zero, e.dbz);
            end
        end
    endtask

    task automatic test_abort;
        int c0, at;
        bit ok, seen;
        exp_t e;
        issue(ALU_MUL, 32'd3, 32'd5, c0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        #2 clear_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL abort_result got=%h want=0", result); end
        @(negedge clock);
        clear_n = 1'b1;
        sb.delete();
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL abort_no_done got=1 want=0"); end
        issue(ALU_ADD, 32'd2, 32'd3, c0);
        wait_done(5, at, ok);
        e = sb.pop_front();
        checks++; if (!ok || at - c0 != e.lat) begin errors++; $display("FAIL post_abort_latency got=%0d want=%0d", at - c0, e.lat); end
        checks++; if (result !== e.res) begin errors++; $display("FAIL post_abort_result got=%h want=%h", result, e.res); end
    endtask

    task automatic test_back_to_back;
        int base, n_done;
        bit both;
        exp_t e;
        @(negedge clock);
        op = ALU_ADD; A = 32'd5; B = 32'd6; start = 1'b1;
        sb.push_back(model(ALU_ADD, 32'd5, 32'd6));
        base   = cyc;
        n_done = 0;
        both   = 1'b0;
        for (int k = 0; k < 60 && n_done < 3; k++) begin
            @(negedge clock);
            if (done === 1'b1 && busy === 1'b1) both = 1'b1;
            if (done === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if (cyc - base != e.lat) begin
                    errors++; $display("FAIL b2b_latency n=%0d got=%0d want=%0d", n_done, cyc - base, e.lat);
                end
                checks++;
                if (result !== e.res) begin
                    errors++; $display("FAIL b2b_result n=%0d got=%h want=%h", n_done, result, e.res);
                end
                base = cyc;
                n_done++;
                if (n_done == 1) begin
                    op = ALU_MUL; A = 32'hFFFF_FFFD; B = 32'hFFFF_FFF7;
                    sb.push_back(model(ALU_MUL, 32'hFFFF_FFFD, 32'hFFFF_FFF7));
                end else if (n_done == 2) begin
                    op = ALU_AND; A = 32'hF0F0_F0F0; B = 32'hFF00_FF00;
                    sb.push_back(model(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++; if (n_done != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", n_done); end
        checks++; if (both) begin errors++; $display("FAIL b2b_busy_done_overlap got=1 want=0"); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_cycle();
        test_mul_stray_start();
        test_muldiv_table();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
